// File: rtl/fas_frame_ctrl.sv
// fas_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer between the FIR filter and the FFT / frequency-analyst back
// end. FIR samples are counted into FRAME_LEN-sample frames and written into a
// two-bank (ping-pong) serial-to-parallel buffer. Each completed bank is handed
// to the FFT, then to the analyst, and a done pulse is issued per frame.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   fir_valid      FIR sample valid this cycle
//   wr_en          buffer write strobe (follows fir_valid)
//   wr_bank        bank being written
//   wr_addr        slot within wr_bank
//   fft_start      one-cycle pulse: FFT may begin reading fft_bank
//   fft_bank       bank the FFT must read
//   fft_done       one-cycle pulse from FFT: bank consumed
//   ana_start      one-cycle pulse: analyst may evaluate FFT outputs
//   ana_done       one-cycle pulse from analyst: result valid
//   done           one-cycle pulse per completed frame
//   frame_cnt      number of completed frames (wraps)
//   overrun        sticky: a frame started on a bank not yet released
// ----------------------------------------------------------------------------
module fas_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fir_valid,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              fft_start,
    output logic              fft_bank,
    input  logic              fft_done,
    output logic              ana_start,
    input  logic              ana_done,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FFT_RUN = 2'd1,
        ANA_RUN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                first_q, first_d;       // first cycle of a run state
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_bank_q, wr_bank_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic                rd_bank_q, rd_bank_d;
    logic                fft_bank_q, fft_bank_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [1:0]          set_mask;
    logic [1:0]          clr_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            first_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            rd_bank_q   <= 1'b0;
            fft_bank_q  <= 1'b0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            bank_full_q <= bank_full_d;
            rd_bank_q   <= rd_bank_d;
            fft_bank_q  <= fft_bank_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        fft_bank_d  = fft_bank_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        set_mask    = 2'b00;
        clr_mask    = 2'b00;
        fft_start   = 1'b0;
        ana_start   = 1'b0;

        // Write side: never stalls; the last slot closes the bank.
        if (fir_valid) begin
            if (wr_addr_q == ADDR_W'(FRAME_LEN - 1)) begin
                wr_addr_d          = '0;
                wr_bank_d          = ~wr_bank_q;
                set_mask[wr_bank_q] = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
            // A new frame starting on a bank the back end still owns.
            if ((wr_addr_q == '0) && bank_full_q[wr_bank_q]) begin
                overrun_d = 1'b1;
            end
        end

        // Read side sequencer.
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d    = FFT_RUN;
                    fft_bank_d = rd_bank_q;
                    first_d    = 1'b1;
                end
            end
            FFT_RUN: begin
                fft_start = first_q;
                if (fft_done) begin
                    clr_mask[rd_bank_q] = 1'b1;
                    rd_bank_d           = ~rd_bank_q;
                    state_d             = ANA_RUN;
                    first_d             = 1'b1;
                end
            end
            ANA_RUN: begin
                ana_start = first_q;
                if (ana_done) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set wins over a same-cycle release of the same bank.
        bank_full_d = (bank_full_q & ~clr_mask) | set_mask;
    end

    // Gated by rst so the strobe also reads 0 while reset is held.
    assign wr_en     = fir_valid & ~rst;
    assign wr_bank   = wr_bank_q;
    assign wr_addr   = wr_addr_q;
    assign fft_bank  = fft_bank_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Testbench for fas_frame_ctrl: directed scenarios plus a randomized stream
// checked against an event-level model (frame ready times, back-end release
// counts) rather than a cycle-accurate copy of the sequencer.
module tb_fas_frame_ctrl;

    localparam int FRAME_LEN = 16;
    localparam int ADDR_W    = 4;
    localparam int CNT_W     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fir_valid = 1'b0;
    logic              fft_done = 1'b0;
    logic              ana_done = 1'b0;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              fft_start;
    logic              fft_bank;
    logic              ana_start;
    logic              done;
    logic [CNT_W-1:0]  frame_cnt;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fas_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
        .ana_start(ana_start), .ana_done(ana_done),
        .done(done), .frame_cnt(frame_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs driven afterwards
    // belong to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fir_valid = 1'($urandom_range(0, 1));
            fft_done  = 1'($urandom_range(0, 1));
            ana_done  = 1'($urandom_range(0, 1));
            #3;
            n_checks++;
            if ({wr_en, wr_bank, wr_addr, fft_start, fft_bank, ana_start, done, frame_cnt, overrun} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got wr_en=%b wr_bank=%b wr_addr=%0d fft_start=%b fft_bank=%b ana_start=%b done=%b frame_cnt=%0d overrun=%b, expected all 0",
                         wr_en, wr_bank, wr_addr, fft_start, fft_bank, ana_start, done, frame_cnt, overrun);
            end
            tick();
        end
        rst = 1'b0; fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #3;
            n_checks++;
            if ({fft_start, ana_start, done, wr_addr} !== '0) begin
                n_fail++;
                $display("FAIL reset_release_idle: got fft_start=%b ana_start=%b done=%b wr_addr=%0d, expected 0",
                         fft_start, ana_start, done, wr_addr);
            end
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            tick();
            fir_valid = (c >= 1 && c <= 16);
            fft_done  = (c == 23);
            ana_done  = (c == 26);
            #3;
            n_checks++;
            if (c <= 16 && (wr_addr !== ADDR_W'(c - 1) || wr_bank !== 1'b0 || wr_en !== 1'b1)) begin
                n_fail++;
                $display("FAIL single_write c=%0d: got addr=%0d bank=%b wr_en=%b, expected addr=%0d bank=0 wr_en=1",
                         c, wr_addr, wr_bank, wr_en, c - 1);
            end
            if (c >= 17 && (wr_bank !== 1'b1 || wr_addr !== '0)) begin
                n_fail++;
                $display("FAIL single_bank c=%0d: got bank=%b addr=%0d, expected bank=1 addr=0", c, wr_bank, wr_addr);
            end
            n_checks++;
            if (fft_start !== (c == 18) || ana_start !== (c == 24) || done !== (c == 27)) begin
                n_fail++;
                $display("FAIL single_pulses c=%0d: got fft_start=%b ana_start=%b done=%b, expected %b %b %b",
                         c, fft_start, ana_start, done, c == 18, c == 24, c == 27);
            end
            n_checks++;
            if (frame_cnt !== CNT_W'(c >= 27 ? 1 : 0) || (c >= 18 && fft_bank !== 1'b0) || overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL single_status c=%0d: got frame_cnt=%0d fft_bank=%b overrun=%b", c, frame_cnt, fft_bank, overrun);
            end
        end
        fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
    endtask

    task automatic test_gapped_frame();
        do_reset();
        for (int c = 1; c <= 35; c++) begin
            tick();
            fir_valid = (c <= 8) || (c >= 19 && c <= 26);
            #3;
            n_checks++;
            if (fft_start !== (c == 28)) begin
                n_fail++;
                $display("FAIL gapped_start c=%0d: got fft_start=%b, expected %b", c, fft_start, c == 28);
            end
            if (c >= 9 && c <= 19) begin
                n_checks++;
                if (wr_addr !== ADDR_W'(8)) begin
                    n_fail++;
                    $display("FAIL gapped_hold c=%0d: got wr_addr=%0d, expected 8", c, wr_addr);
                end
            end
        end
        fir_valid = 1'b0;
    endtask

    task automatic test_stray_and_reset();
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            tick();
            fft_done  = (c <= 3) || (c == 25);
            ana_done  = (c <= 3) || (c == 27);
            fir_valid = (c >= 4 && c <= 19);
            rst       = (c == 23);
            #3;
            n_checks++;
            if (fft_start !== (c == 21) || ana_start !== 1'b0 || done !== 1'b0 || frame_cnt !== '0) begin
                n_fail++;
                $display("FAIL stray_reset c=%0d: got fft_start=%b ana_start=%b done=%b frame_cnt=%0d, expected fft_start=%b others 0",
                         c, fft_start, ana_start, done, frame_cnt, c == 21);
            end
            if (c >= 23) begin
                n_checks++;
                if (wr_addr !== '0 || wr_bank !== 1'b0 || fft_bank !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stray_after_reset c=%0d: got wr_addr=%0d wr_bank=%b fft_bank=%b, expected 0",
                             c, wr_addr, wr_bank, fft_bank);
                end
            end
        end
        rst = 1'b0; fft_done = 1'b0; ana_done = 1'b0; fir_valid = 1'b0;
    endtask

    // Stream n samples with the given valid density; the bench plays FFT and
    // analyst with random response delays. Expected behaviour is derived from
    // frame completion times: frame k may start at max(ready_k+2, prev_ana_done+2).
    task automatic run_model(input string name, input int n_samples, input int pct_valid,
                             input int fd_min, input int fd_max, input int ad_min, input int ad_max,
                             input bit withhold);
        int  ready_q[$];
        int  sent, frames_started, frames_done, released;
        int  fft_done_at, ana_done_at, last_ana_done, last_valid;
        bit  busy, exp_start, exp_ovr, exp_bank, v;
        int  c;
        sent = 0; frames_started = 0; frames_done = 0; released = 0;
        fft_done_at = -10; ana_done_at = -10; last_ana_done = -100; last_valid = 0;
        busy = 0; exp_ovr = 0; exp_bank = 0;
        do_reset();
        c = 0;
        forever begin
            tick();
            c = cyc;
            if (sent == n_samples && (withhold ? (c > last_valid + 6)
                    : (frames_done == n_samples / FRAME_LEN && c > last_ana_done + 2))) break;
            if (c > 3000) begin
                n_checks++; n_fail++;
                $display("FAIL %s_timeout: got %0d frames done, expected %0d", name, frames_done, n_samples / FRAME_LEN);
                break;
            end
            v = (sent < n_samples) && ($urandom_range(0, 99) < pct_valid);
            exp_start = 0;
            if (!busy && ready_q.size() > 0) begin
                if (c == ((ready_q[0] + 2 > last_ana_done + 2) ? ready_q[0] + 2 : last_ana_done + 2)) begin
                    exp_start = 1; busy = 1;
                    void'(ready_q.pop_front());
                    exp_bank = frames_started[0];
                    frames_started++;
                    fft_done_at = withhold ? -10 : c + int'($urandom_range(fd_min, fd_max));
                end
            end
            if (c == fft_done_at + 1)
                ana_done_at = c + int'($urandom_range(ad_min, ad_max));
            fir_valid = v;
            fft_done  = (c == fft_done_at);
            ana_done  = (c == ana_done_at);
            #3;
            n_checks++;
            if (wr_en !== v || wr_addr !== ADDR_W'(sent % FRAME_LEN) || wr_bank !== 1'((sent / FRAME_LEN) % 2)) begin
                n_fail++;
                $display("FAIL %s_write c=%0d: got wr_en=%b addr=%0d bank=%b, expected %b %0d %0d",
                         name, c, wr_en, wr_addr, wr_bank, v, sent % FRAME_LEN, (sent / FRAME_LEN) % 2);
            end
            n_checks++;
            if (fft_start !== exp_start || ana_start !== (c == fft_done_at + 1) || done !== (c == last_ana_done + 1)) begin
                n_fail++;
                $display("FAIL %s_pulses c=%0d: got fft_start=%b ana_start=%b done=%b, expected %b %b %b",
                         name, c, fft_start, ana_start, done, exp_start, c == fft_done_at + 1, c == last_ana_done + 1);
            end
            n_checks++;
            if (frame_cnt !== CNT_W'(frames_done) || fft_bank !== exp_bank || overrun !== exp_ovr) begin
                n_fail++;
                $display("FAIL %s_status c=%0d: got frame_cnt=%0d fft_bank=%b overrun=%b, expected %0d %b %b",
                         name, c, frame_cnt, fft_bank, overrun, frames_done, exp_bank, exp_ovr);
            end
            // Overrun: a frame begins while two completed frames are unreleased.
            if (v && (sent % FRAME_LEN == 0) && (sent / FRAME_LEN - released >= 2)) exp_ovr = 1;
            if (c == fft_done_at) released++;
            if (c == ana_done_at) begin
                last_ana_done = c; frames_done++; busy = 0;
            end
            if (v) begin
                sent++; last_valid = c;
                if (sent % FRAME_LEN == 0) ready_q.push_back(c);
            end
        end
        fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
        $display("%s: %0d samples, %0d frames done, overrun=%b", name, sent, frames_done, overrun);
    endtask

    task automatic test_back_to_back();
        run_model("back_to_back", 32, 100, 3, 3, 2, 2, 1'b0);
    endtask

    task automatic test_overrun();
        run_model("overrun", 48, 100, 0, 0, 1, 1, 1'b1);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got overrun=%b, expected 1", overrun);
        end
    endtask

    task automatic test_random_stream();
        for (int r = 0; r < 4; r++)
            run_model("random_stream", 80, 55 + 15 * r, 0, 4, 1, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gapped_frame();
        test_back_to_back();
        test_overrun();
        test_stray_and_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fas_frame_ctrl.md
Name: fas_frame_ctrl

Overview:
Frame sequencer between the FIR filter and the FFT/analyst back end of the FAS design. It counts FIR output samples into 16-sample frames and steers them into a ping-pong (two-bank) serial-to-parallel buffer. For each complete frame it issues start pulses to the FFT, then to the frequency analyst, and reports per-frame completion. It also flags buffer overrun when the FIR stream outruns the back end.

Parameters:
FRAME_LEN, 16, samples per frame; must be a power of two.
ADDR_W, 4, buffer address width; equals log2(FRAME_LEN).
CNT_W, 8, width of the completed-frame counter.

Ports:
clk  in  1  clock
rst  in  1  reset
fir_valid  in  1  FIR output sample valid this cycle
wr_en  out  1  write strobe for the serial-to-parallel buffer
wr_bank  out  1  buffer bank being written
wr_addr  out  ADDR_W  slot within wr_bank
fft_start  out  1  one-cycle pulse: FFT may begin on fft_bank
fft_bank  out  1  bank the FFT must read
fft_done  in  1  one-cycle pulse from FFT: computation finished, bank consumed
ana_start  out  1  one-cycle pulse: analyst may evaluate FFT outputs
ana_done  in  1  one-cycle pulse from analyst: freq is valid
done  out  1  one-cycle pulse per completed frame
frame_cnt  out  CNT_W  number of completed frames
overrun  out  1  sticky error flag

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. Reset clears every register. All outputs read 0: wr_addr=0, wr_bank=0, fft_bank=0, frame_cnt=0, overrun=0, bank_full[1:0]=0. The FSM enters IDLE.
- Write side:
  - wr_en = fir_valid (combinational).
  - On each fir_valid cycle, wr_addr increments.
  - When fir_valid and wr_addr==FRAME_LEN-1: wr_addr wraps to 0, wr_bank toggles, and bank_full[wr_bank] is set.
  - If fir_valid is low, wr_addr and wr_bank hold. Gaps inside a frame are legal.
- Overrun:
  - Condition: fir_valid and wr_addr==0 and bank_full[wr_bank]==1 (the frame start lands on an unreleased bank).
  - Effect: overrun sets and stays set until reset. The write still happens.
  - A set and a clear of the same bank in the same cycle resolve as set.
- Read FSM (registered state):
  - IDLE: if bank_full[rd_bank], go to FFT_RUN. fft_bank takes rd_bank.
  - FFT_RUN: fft_start is high only in the first cycle of FFT_RUN. Stay until fft_done. On fft_done, clear bank_full[rd_bank], toggle rd_bank, and go to ANA_RUN.
  - ANA_RUN: ana_start is high only in the first cycle of ANA_RUN. Stay until ana_done. On ana_done, go to IDLE, pulse done in the next cycle, and increment frame_cnt (wraps 2^CNT_W-1 -> 0).
- Latency:
  - 16th sample of a frame in cycle t -> fft_start in cycle t+2, provided the FSM is in IDLE.
  - fft_done in cycle u -> ana_start in u+1.
  - ana_done in cycle v -> done and frame_cnt update visible in v+1. The earliest next fft_start is v+2.
- Ignored pulses: fft_done outside FFT_RUN and ana_done outside ANA_RUN are ignored. A fft_done arriving in the same cycle as fft_start is accepted.
- Writing ahead: the write side never stalls. Writing one frame ahead while the back end works is legal.
- Reset mid-operation: returns to the reset state immediately. A partially written frame is discarded.
- fft_bank changes only on the IDLE -> FFT_RUN transition.

Test Plan:
1. Reset check: assert rst for 3 cycles with toggling inputs -> all outputs 0; after release, FSM in IDLE and no start pulses.
2. Single frame: fir_valid high in cycles 1..16 -> wr_addr 0..15 on bank 0, wr_bank=1 from cycle 17, fft_start in cycle 18 with fft_bank=0. Then fft_done in cycle 23 -> ana_start in 24. Then ana_done in 26 -> done in 27, frame_cnt=1.
3. Gapped frame: 8 valid samples, 10 idle cycles, 8 valid samples -> exactly one fft_start, 2 cycles after the 16th sample. wr_addr holds at 8 during the gap.
4. Back-to-back frames: 32 continuous samples, fft_done 3 cycles after each start, ana_done 2 cycles after each ana_start -> two frames complete with fft_bank 0 then 1, frame_cnt=2, overrun=0.
5. Overrun: 48 continuous samples, fft_done withheld -> overrun sets in the cycle sample 33 arrives (bank 0 still full) and stays 1. Only one fft_start is issued.
6. Stray and reset: fft_done and ana_done pulsed while IDLE -> no state change. Then rst asserted mid-FFT_RUN -> frame_cnt=0, bank_full cleared, and no ana_start follows a later fft_done.
